// File: rtl/ysyx_23060236_axi_sram.sv
// rtl/ysyx_23060236_axi_sram.sv - AXI4 slave responder over a word-addressed two-port SRAM
module ysyx_23060236_axi_sram #(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0f00_0000,
  parameter int          RD_GAP = 0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        awready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  output logic        wready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        bready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        arready,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        rready,
  output logic        rvalid,
  output logic [1:0]  rresp,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int          WORDS     = 1 << ADDR_W;
  localparam logic [31:0] WIN_BYTES = 32'd4 << ADDR_W;
  localparam bit          NO_GAP    = (RD_GAP == 0);
  localparam logic [2:0]  GAP_LOAD  = 3'(RD_GAP > 0 ? RD_GAP - 1 : 0);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_SLV  = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_GAP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // A beat is in error if it falls outside the window, is wider than a
  // word, or belongs to a WRAP burst whose length cannot form a wrap span.
  function automatic logic beat_err(input logic [31:0] addr, input logic [2:0] size,
                                    input logic [1:0] burst, input logic [7:0] len);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return ((addr - BASE) >= WIN_BYTES) || (size > 3'd2) || bad_wrap;
  endfunction

  // Word index relative to the window base; only meaningful for in-window beats.
  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] addr);
    return ADDR_W'((addr - BASE) >> 2);
  endfunction

  // Address of the following beat for FIXED / INCR / WRAP bursts.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [7:0] len);
    logic [31:0] step;
    logic [31:0] span_mask;
    logic [31:0] res;
    step      = 32'd1 << size;
    span_mask = ((32'(len) + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   res = addr;
      2'b10:   res = (addr & ~span_mask) | ((addr + step) & span_mask);
      default: res = addr + step;
    endcase
    return res;
  endfunction

  logic [31:0] mem [WORDS];

  // Ready outputs stay low until the first clock edge after reset release.
  logic live;

  r_state_t    r_state, r_state_nx;
  logic [31:0] r_addr;
  logic [3:0]  r_id;
  logic [7:0]  r_len, r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [2:0]  r_gap_cnt;
  logic [31:0] r_data_q;
  logic        r_err, r_last, ar_fire, r_fire;
  logic        r_load, r_load_err;
  logic [31:0] r_load_addr;

  w_state_t    w_state, w_state_nx;
  logic [31:0] w_addr;
  logic [3:0]  w_id;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_bad, w_over, w_err, aw_fire, w_fire, w_we;

  assign r_err   = beat_err(r_addr, r_size, r_burst, r_len);
  assign r_last  = (r_cnt == r_len);
  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;
  assign rdata   = r_data_q;

  assign w_err   = beat_err(w_addr, w_size, w_burst, w_len);
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign w_we    = w_fire && !w_over && !w_err;

  // Liveness flag that gates the address-channel readies out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Read FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= R_IDLE;
    else        r_state <= r_state_nx;
  end

  // Read FSM next state and R/AR channel outputs.
  always_comb begin
    r_state_nx = r_state;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rid        = 4'd0;
    rlast      = 1'b0;
    rresp      = RESP_OKAY;
    case (r_state)
      R_IDLE: begin
        arready = live;
        if (arvalid && live) r_state_nx = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rid    = r_id;
        rlast  = r_last;
        rresp  = r_err ? RESP_SLV : RESP_OKAY;
        if (rready) begin
          if (r_last)      r_state_nx = R_IDLE;
          else if (NO_GAP) r_state_nx = R_DATA;
          else             r_state_nx = R_GAP;
        end
      end
      R_GAP: begin
        if (r_gap_cnt == 3'd0) r_state_nx = R_DATA;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Pick the address whose word must be fetched for the next R_DATA entry.
  always_comb begin
    r_load      = 1'b0;
    r_load_addr = r_addr;
    r_load_err  = r_err;
    if (ar_fire) begin
      r_load      = 1'b1;
      r_load_addr = araddr;
      r_load_err  = beat_err(araddr, arsize, arburst, arlen);
    end else if (r_fire && !r_last && NO_GAP) begin
      r_load      = 1'b1;
      r_load_addr = next_addr(r_addr, r_size, r_burst, r_len);
      r_load_err  = beat_err(r_load_addr, r_size, r_burst, r_len);
    end else if (r_state == R_GAP && r_gap_cnt == 3'd0) begin
      r_load      = 1'b1;
      r_load_addr = r_addr;
      r_load_err  = r_err;
    end
  end

  // Read-port register: captures the old word on a same-cycle write, and
  // holds steady through rready stalls. Error beats read back as zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data_q <= 32'd0;
    end else if (r_load) begin
      r_data_q <= r_load_err ? 32'd0 : mem[word_idx(r_load_addr)];
    end
  end

  // Read burst bookkeeping: latched request, beat counter, gap timer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr    <= 32'd0;
      r_id      <= 4'd0;
      r_len     <= 8'd0;
      r_cnt     <= 8'd0;
      r_size    <= 3'd0;
      r_burst   <= 2'd0;
      r_gap_cnt <= 3'd0;
    end else if (ar_fire) begin
      r_addr  <= araddr;
      r_id    <= arid;
      r_len   <= arlen;
      r_cnt   <= 8'd0;
      r_size  <= arsize;
      r_burst <= arburst;
    end else if (r_fire) begin
      r_addr    <= next_addr(r_addr, r_size, r_burst, r_len);
      r_cnt     <= r_cnt + 8'd1;
      r_gap_cnt <= GAP_LOAD;
    end else if (r_state == R_GAP) begin
      r_gap_cnt <= r_gap_cnt - 3'd1;
    end
  end

  // Write FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) w_state <= W_IDLE;
    else        w_state <= w_state_nx;
  end

  // Write FSM next state and AW/W/B channel outputs.
  always_comb begin
    w_state_nx = w_state;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    bid        = 4'd0;
    bresp      = RESP_OKAY;
    case (w_state)
      W_IDLE: begin
        awready = live;
        if (awvalid && live) w_state_nx = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) w_state_nx = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        bid    = w_id;
        bresp  = w_bad ? RESP_SLV : RESP_OKAY;
        if (bready) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Write burst bookkeeping: latched request, beat count, sticky error and
  // the overrun flag that swallows beats after len until wlast shows up.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_addr  <= 32'd0;
      w_id    <= 4'd0;
      w_len   <= 8'd0;
      w_cnt   <= 8'd0;
      w_size  <= 3'd0;
      w_burst <= 2'd0;
      w_bad   <= 1'b0;
      w_over  <= 1'b0;
    end else if (aw_fire) begin
      w_addr  <= awaddr;
      w_id    <= awid;
      w_len   <= awlen;
      w_cnt   <= 8'd0;
      w_size  <= awsize;
      w_burst <= awburst;
      w_bad   <= 1'b0;
      w_over  <= 1'b0;
    end else if (w_fire && !w_over) begin
      if (w_err)                       w_bad <= 1'b1;
      if (wlast && (w_cnt != w_len))   w_bad <= 1'b1;
      if (!wlast && (w_cnt == w_len)) begin
        w_bad  <= 1'b1;
        w_over <= 1'b1;
      end
      w_addr <= next_addr(w_addr, w_size, w_burst, w_len);
      w_cnt  <= w_cnt + 8'd1;
    end
  end

  // Write port: byte-lane enables straight from wstrb; array is never reset.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (w_we && wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_axi_sram.sv
// tb/tb_ysyx_23060236_axi_sram.sv - scoreboard bench for the AXI4 SRAM responder
module tb_ysyx_23060236_axi_sram;
  localparam int          ADDR_W = 10;
  localparam int          WORDS  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h0f00_0000;
  localparam logic [31:0] WIN    = 32'd4 << ADDR_W;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic awready, awvalid, wready, wvalid, wlast, bready, bvalid;
  logic arready, arvalid, rready, rvalid, rlast;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  ysyx_23060236_axi_sram #(.ADDR_W(ADDR_W), .BASE(BASE), .RD_GAP(0)) dut (
    .clock(clock), .reset(reset),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] model [WORDS];
  logic [31:0] wb_data [260];
  logic [3:0]  wb_strb [260];
  int          checks = 0;
  int          failures = 0;
  int          rr_mode = 0;
  bit          br_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    int unsigned bytes;
    int unsigned span;
    logic [31:0] lo;
    bytes = 32'd1 << size;
    span  = (32'(len) + 1) * bytes;
    if (burst == 2'b00) return a;
    if (burst == 2'b10) begin
      lo = a - (a % span);
      return lo + (((a - lo) + 32'(i) * bytes) % span);
    end
    return a + 32'(i) * bytes;
  endfunction

  function automatic bit beat_bad(input logic [31:0] a, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
    bit wrap_bad;
    wrap_bad = (burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return ((a - BASE) >= WIN) || (size > 3'd2) || wrap_bad;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2) % WORDS;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares every presented R beat / B response to the queue head.
  always @(negedge clock) begin
    if (reset) begin
      if (rvalid) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL r_unexpected: got rvalid with rdata %h, expected no beat", rdata);
        end else begin
          chk("rdata", rdata, rq[0].data);
          chk("rresp", 32'(rresp), 32'(rq[0].resp));
          chk("rlast", 32'(rlast), 32'(rq[0].last));
          chk("rid", 32'(rid), 32'(rq[0].id));
          if (rready) void'(rq.pop_front());
        end
      end
      if (bvalid) begin
        if (bq.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected: got bvalid with bresp %h, expected none", bresp);
        end else begin
          chk("bresp", 32'(bresp), 32'(bq[0].resp));
          chk("bid", 32'(bid), 32'(bq[0].id));
          if (bready) void'(bq.pop_front());
        end
      end
    end
  end

  // Response-channel ready drivers.
  initial begin
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rr_mode)
        0:       rready = 1'b1;
        1:       rready = !rready;
        2:       rready = 1'($urandom_range(0, 1));
        default: rready = 1'b0;
      endcase
      bready = br_en ? ($urandom_range(0, 2) != 0) : 1'b0;
    end
  end

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    rexp_t e;
    logic [31:0] ba;
    bit bad;
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      ba     = beat_addr(a, i, len, size, burst);
      bad    = beat_bad(ba, len, size, burst);
      e.data = bad ? 32'd0 : model[widx(ba)];
      e.resp = bad ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      e.id   = id;
      rq.push_back(e);
    end
    araddr = a; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!arready && n < 50);
    if (!arready) begin
      checks++; failures++;
      $display("FAIL ar_handshake: got no arready in %0d cycles, expected arready", n);
      arvalid = 1'b0;
      return;
    end
    step();
    arvalid = 1'b0;
    @(negedge clock);
    chk("r_first_beat_latency", 32'(rvalid), 32'd1);
  endtask

  task automatic wait_r();
    int n;
    n = 0;
    while (rq.size() != 0 && n < 5000) begin @(negedge clock); n++; end
    if (rq.size() != 0) begin
      checks++; failures++;
      $display("FAIL r_drain: got %0d beats outstanding, expected 0", rq.size());
      rq.delete();
    end
    step();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int nbeats);
    bexp_t e;
    logic [31:0] ba;
    bit bad;
    int n;
    bad = (nbeats != int'(len) + 1);
    for (int i = 0; i < nbeats && i <= int'(len); i++) begin
      ba = beat_addr(a, i, len, size, burst);
      if (beat_bad(ba, len, size, burst)) bad = 1'b1;
      else for (int b = 0; b < 4; b++)
        if (wb_strb[i][b]) model[widx(ba)][8*b +: 8] = wb_data[i][8*b +: 8];
    end
    e.resp = bad ? 2'b10 : 2'b00;
    e.id   = id;
    bq.push_back(e);
    awaddr = a; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!awready && n < 50);
    if (!awready) begin
      checks++; failures++;
      $display("FAIL aw_handshake: got no awready in %0d cycles, expected awready", n);
      awvalid = 1'b0;
      return;
    end
    step();
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wb_data[i]; wstrb = wb_strb[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!wready && n < 50);
      if (!wready) begin
        checks++; failures++;
        $display("FAIL w_handshake: got no wready on beat %0d, expected wready", i);
        wvalid = 1'b0;
        return;
      end
      step();
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; step(); end
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    while (bq.size() != 0 && n < 2000) begin @(negedge clock); n++; end
    if (bq.size() != 0) begin
      checks++; failures++;
      $display("FAIL b_drain: got %0d responses outstanding, expected 0", bq.size());
      bq.delete();
    end
    step();
  endtask

  task automatic pulse_reset_check(input string tag);
    #2 reset = 1'b0;
    #1;
    chk({tag, "_rvalid_in_reset"}, 32'(rvalid), 32'd0);
    chk({tag, "_bvalid_in_reset"}, 32'(bvalid), 32'd0);
    chk({tag, "_readies_in_reset"}, 32'({awready, arready, wready}), 32'd0);
    rq.delete();
    bq.delete();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_readies_before_edge"}, 32'({awready, arready}), 32'd0);
    @(negedge clock);
    chk({tag, "_readies_after_release"}, 32'({awready, arready}), 32'd3);
    step();
  endtask

  initial begin
    #500000;
    checks++; failures++;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nb;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;

    repeat (3) @(negedge clock);
    chk("reset_outputs", 32'({awready, arready, wready, rvalid, bvalid, rlast, rresp, bresp, rid, bid}), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    #2 reset = 1'b1;
    #1 chk("ready_before_first_edge", 32'({awready, arready}), 32'd0);
    @(negedge clock);
    chk("ready_after_first_edge", 32'({awready, arready}), 32'd3);
    step();

    // Fill the whole array with long INCR bursts so the model is fully known.
    rr_mode = 2;
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'hF; end
      do_write(BASE + 32'(blk * 1024), 8'd255, 3'd2, 2'b01, 4'(blk), 256);
      wait_b();
    end

    wb_data[0] = 32'hDEADBEEF; wb_strb[0] = 4'hF;
    do_write(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 4'h5, 1); wait_b();
    do_read(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 4'h9); wait_r();

    wb_data[0] = 32'h11223344; wb_strb[0] = 4'hF;
    do_write(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 4'h1, 1); wait_b();
    wb_data[0] = 32'h000000AA; wb_strb[0] = 4'b0001;
    do_write(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 4'h2, 1); wait_b();
    do_read(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 4'h3); wait_r();
    chk("strobe_merge_model", model[8], 32'h112233AA);

    rr_mode = 1;
    do_read(BASE, 8'd3, 3'd2, 2'b01, 4'h4); wait_r();
    do_read(BASE + 32'h8, 8'd3, 3'd2, 2'b10, 4'h6); wait_r();
    do_read(BASE + 32'h8, 8'd2, 3'd2, 2'b10, 4'h7); wait_r();
    rr_mode = 2;

    do_read(BASE + WIN, 8'd1, 3'd2, 2'b01, 4'h8); wait_r();
    wb_data[0] = $urandom; wb_strb[0] = 4'hF;
    do_write(BASE - 32'd4, 8'd0, 3'd2, 2'b01, 4'hB, 1); wait_b();
    do_read(BASE + WIN - 32'd4, 8'd0, 3'd2, 2'b01, 4'hC); wait_r();
    do_read(BASE + WIN - 32'd8, 8'd3, 3'd2, 2'b01, 4'hD); wait_r();
    do_read(BASE, 8'd1, 3'd3, 2'b01, 4'hE); wait_r();

    for (int i = 0; i < 4; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'(i + 5); end
    do_write(BASE + 32'h40, 8'd2, 3'd2, 2'b01, 4'h1, 2); wait_b();
    do_write(BASE + 32'h40, 8'd1, 3'd2, 2'b01, 4'h2, 3); wait_b();
    do_read(BASE + 32'h40, 8'd3, 3'd2, 2'b01, 4'h3); wait_r();

    rr_mode = 0;
    do_read(BASE, 8'd7, 3'd2, 2'b01, 4'h7);
    repeat (2) @(negedge clock);
    pulse_reset_check("mid_read");
    do_read(BASE + 32'h10, 8'd1, 3'd2, 2'b01, 4'h2); wait_r();

    br_en = 1'b0;
    step();
    wb_data[0] = $urandom; wb_strb[0] = 4'hF;
    do_write(BASE + 32'h80, 8'd0, 3'd2, 2'b01, 4'hA, 1);
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clock); n++; end
    chk("bvalid_before_reset", 32'(bvalid), 32'd1);
    pulse_reset_check("w_resp");
    br_en = 1'b1;
    wb_data[0] = $urandom; wb_strb[0] = 4'hF;
    do_write(BASE + 32'h84, 8'd0, 3'd2, 2'b01, 4'h3, 1); wait_b();
    do_read(BASE + 32'h80, 8'd1, 3'd2, 2'b01, 4'h4); wait_r();

    rr_mode = 2;
    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(0, 9);
      burst = (n < 2) ? 2'b00 : (n < 7) ? 2'b01 : 2'b10;
      size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if (burst == 2'b10 && $urandom_range(0, 7) != 0) begin
        n = $urandom_range(0, 3);
        len = 8'((2 << n) - 1);
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      n = $urandom_range(0, 9);
      if (n < 8)       a = BASE + ($urandom_range(0, WIN - 1) & ~((32'd1 << size) - 32'd1));
      else if (n == 8) a = BASE + WIN - 32'(4 * $urandom_range(1, 8));
      else             a = BASE - 32'(4 * $urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        nb = int'(len) + 1;
        n  = $urandom_range(0, 7);
        if (n == 0) nb = nb + 1;
        else if (n == 1 && len > 0) nb = nb - 1;
        for (int i = 0; i < nb; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'($urandom); end
        do_write(a, len, size, burst, 4'($urandom), nb); wait_b();
      end else begin
        do_read(a, len, size, burst, 4'($urandom)); wait_r();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
